// File: rtl/xy2_rx_multi.sv
// XY2-100 / XY2-100-E multi-lane setpoint receiver: oversampled in the clk_in
// domain, per-channel 16/18-bit decode, parity/control/framing checks, link timeout.
module xy2_rx_multi #(
  parameter int          NCH         = 2,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT_CYC = 8200,
  parameter logic [17:0] POS_RST     = 18'h20000
) (
  input  logic                clk_in,
  input  logic                cnt_rstn,
  input  logic                xy_clk,
  input  logic                xy_sync,
  input  logic [NCH-1:0]      xy_data,
  input  logic                err_clr,
  output logic [NCH*18-1:0]   pos,
  output logic [NCH-1:0]      pos_valid,
  output logic [NCH-1:0]      mode18,
  output logic [NCH*16-1:0]   ch_err_cnt,
  output logic [15:0]         frame_err_cnt,
  output logic                link_ok,
  output logic                xy_status
);

  localparam int                IW      = NCH + 2;
  localparam int                TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT_CYC);
  localparam logic [15:0]       CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    PAR   = 2'd2,
    CHECK = 2'd3
  } state_t;

  function automatic logic parity_ok(input logic [19:0] frame);
    return ~(^frame);
  endfunction

  // Bit 19 (first on the wire) set means an 18-bit frame; otherwise only 001 is legal.
  function automatic logic ctrl_ok(input logic [19:0] frame);
    return frame[19] | (frame[19:17] == 3'b001);
  endfunction

  function automatic logic [17:0] frame_pos(input logic [19:0] frame);
    return frame[19] ? frame[18:1] : {frame[16:1], 2'b00};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

  logic [IW-1:0]          sync_r [SYNC_STAGES];
  logic [1:0]             hist_r;
  logic [IW-1:0]          cur_s;
  logic                   clk_fall_s;
  logic                   sync_rise_s;
  logic                   sync_fall_s;
  logic [NCH-1:0]         data_s;

  state_t                 state_r, state_s;
  logic [4:0]             bit_cnt_r, bit_cnt_s;
  logic [NCH-1:0][19:0]   sr_r, sr_s;
  logic                   frame_err_s;
  logic                   check_s;
  logic [NCH-1:0]         ok_s;

  logic [NCH-1:0][17:0]   pos_r;
  logic [NCH-1:0]         pos_valid_r;
  logic [NCH-1:0]         mode18_r;
  logic [NCH-1:0][15:0]   ch_err_cnt_r;
  logic [15:0]            frame_err_cnt_r;
  logic [TMO_W-1:0]       tmo_cnt_r;
  logic                   link_ok_r;
  logic                   sticky_r;
  logic                   xy_status_r;

  assign cur_s       = sync_r[SYNC_STAGES-1];
  assign clk_fall_s  = hist_r[0] & ~cur_s[0];
  assign sync_rise_s = ~hist_r[1] & cur_s[1];
  assign sync_fall_s = hist_r[1] & ~cur_s[1];
  assign data_s      = cur_s[IW-1:2];

  // Input synchroniser chain plus history of clk/sync for edge detection.
  always_ff @(posedge clk_in or negedge cnt_rstn) begin
    if (!cnt_rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= {IW{1'b0}};
      hist_r <= 2'b00;
    end else begin
      sync_r[0] <= {xy_data, xy_sync, xy_clk};
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
      hist_r <= cur_s[1:0];
    end
  end

  // Frame FSM state, bit counter and per-lane shift registers.
  always_ff @(posedge clk_in or negedge cnt_rstn) begin
    if (!cnt_rstn) begin
      state_r   <= IDLE;
      bit_cnt_r <= 5'd0;
      sr_r      <= {(NCH*20){1'b0}};
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      sr_r      <= sr_s;
    end
  end

  // Next-state logic; a coincident clk fall is shifted before the sync-fall count check.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    sr_s        = sr_r;
    frame_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sync_rise_s) begin
          state_s   = DATA;
          bit_cnt_s = 5'd0;
          sr_s      = {(NCH*20){1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      DATA: begin
        if (sync_rise_s) begin
          frame_err_s = 1'b1;
          bit_cnt_s   = 5'd0;
          sr_s        = {(NCH*20){1'b0}};
        end else begin
          if (clk_fall_s) begin
            for (int i = 0; i < NCH; i++) sr_s[i] = {sr_r[i][18:0], data_s[i]};
            bit_cnt_s = bit_cnt_r + 5'd1;
          end else begin
            bit_cnt_s = bit_cnt_r;
          end
          if (sync_fall_s) begin
            if (bit_cnt_s == 5'd19) begin
              state_s = PAR;
            end else begin
              frame_err_s = 1'b1;
              state_s     = IDLE;
            end
          end else if (bit_cnt_s == 5'd20) begin
            frame_err_s = 1'b1;
            state_s     = IDLE;
          end else begin
            state_s = DATA;
          end
        end
      end
      PAR: begin
        if (sync_rise_s) begin
          frame_err_s = 1'b1;
          state_s     = DATA;
          bit_cnt_s   = 5'd0;
          sr_s        = {(NCH*20){1'b0}};
        end else if (clk_fall_s) begin
          for (int i = 0; i < NCH; i++) sr_s[i] = {sr_r[i][18:0], data_s[i]};
          state_s = CHECK;
        end else begin
          state_s = PAR;
        end
      end
      CHECK: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Per-channel frame validity, only meaningful in CHECK.
  always_comb begin
    check_s = (state_r == CHECK);
    ok_s    = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) ok_s[i] = parity_ok(sr_r[i]) & ctrl_ok(sr_r[i]);
  end

  // Position, mode and update strobe per channel.
  always_ff @(posedge clk_in or negedge cnt_rstn) begin
    if (!cnt_rstn) begin
      for (int i = 0; i < NCH; i++) pos_r[i] <= POS_RST;
      pos_valid_r <= {NCH{1'b0}};
      mode18_r    <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (check_s && ok_s[i]) begin
          pos_r[i]       <= frame_pos(sr_r[i]);
          mode18_r[i]    <= sr_r[i][19];
          pos_valid_r[i] <= 1'b1;
        end else begin
          pos_valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating error counters and sticky error; err_clr beats a same-cycle increment.
  always_ff @(posedge clk_in or negedge cnt_rstn) begin
    if (!cnt_rstn) begin
      ch_err_cnt_r    <= {(NCH*16){1'b0}};
      frame_err_cnt_r <= 16'd0;
      sticky_r        <= 1'b0;
    end else if (err_clr) begin
      ch_err_cnt_r    <= {(NCH*16){1'b0}};
      frame_err_cnt_r <= 16'd0;
      sticky_r        <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (check_s && !ok_s[i]) ch_err_cnt_r[i] <= sat_inc(ch_err_cnt_r[i]);
      end
      if (frame_err_s) frame_err_cnt_r <= sat_inc(frame_err_cnt_r);
      if (frame_err_s || (check_s && !(&ok_s))) sticky_r <= 1'b1;
    end
  end

  // Link supervision and host status.
  always_ff @(posedge clk_in or negedge cnt_rstn) begin
    if (!cnt_rstn) begin
      tmo_cnt_r   <= {TMO_W{1'b0}};
      link_ok_r   <= 1'b0;
      xy_status_r <= 1'b1;
    end else begin
      if (sync_rise_s) begin
        tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (tmo_cnt_r != TMO_MAX) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
      if (tmo_cnt_r == TMO_MAX) begin
        link_ok_r <= 1'b0;
      end else if (check_s && (|ok_s)) begin
        link_ok_r <= 1'b1;
      end
      xy_status_r <= ~link_ok_r | sticky_r;
    end
  end

  assign pos           = pos_r;
  assign pos_valid     = pos_valid_r;
  assign mode18        = mode18_r;
  assign ch_err_cnt    = ch_err_cnt_r;
  assign frame_err_cnt = frame_err_cnt_r;
  assign link_ok       = link_ok_r;
  assign xy_status     = xy_status_r;

endmodule

// File: tb/tb_xy2_rx_multi.sv
// Directed bench for xy2_rx_multi: drives XY2-100 frames on two lanes and
// checks decoded positions, strobes, error counters, link timeout and reset.
module tb_xy2_rx_multi;

  localparam int          NCH     = 2;
  localparam int          HALF    = 4;
  localparam int          TMO     = 8200;
  localparam logic [17:0] POS_RST = 18'h20000;

  logic             clk_in   = 1'b0;
  logic             cnt_rstn = 1'b0;
  logic             xy_clk   = 1'b0;
  logic             xy_sync  = 1'b0;
  logic [NCH-1:0]   xy_data  = 2'b00;
  logic             err_clr  = 1'b0;
  logic [NCH*18-1:0] pos;
  logic [NCH-1:0]   pos_valid;
  logic [NCH-1:0]   mode18;
  logic [NCH*16-1:0] ch_err_cnt;
  logic [15:0]      frame_err_cnt;
  logic             link_ok;
  logic             xy_status;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int pv_x     = 0;
  int pv_y     = 0;
  int px0, py0;

  xy2_rx_multi #(
    .NCH(NCH), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO), .POS_RST(POS_RST)
  ) dut (
    .clk_in(clk_in), .cnt_rstn(cnt_rstn), .xy_clk(xy_clk), .xy_sync(xy_sync),
    .xy_data(xy_data), .err_clr(err_clr), .pos(pos), .pos_valid(pos_valid),
    .mode18(mode18), .ch_err_cnt(ch_err_cnt), .frame_err_cnt(frame_err_cnt),
    .link_ok(link_ok), .xy_status(xy_status)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc  <= cyc + 1;
    pv_x <= pv_x + int'(pos_valid[0]);
    pv_y <= pv_y + int'(pos_valid[1]);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bits go out MSB first; sync is high for the first 'high' bits.
  task automatic send_bits(input logic [19:0] fx, input logic [19:0] fy, input int high, input int total);
    for (int b = 0; b < total; b++) begin
      xy_clk  = 1'b1;
      xy_sync = (b < high);
      xy_data = {fy[19-b], fx[19-b]};
      if (b == 0 && high > 0) rise_cyc = cyc;
      repeat (HALF) @(negedge clk_in);
      xy_clk = 1'b0;
      repeat (HALF) @(negedge clk_in);
    end
  endtask

  task automatic send_frame(input logic [19:0] fx, input logic [19:0] fy);
    px0 = pv_x;
    py0 = pv_y;
    send_bits(fx, fy, 19, 20);
    repeat (6) @(negedge clk_in);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk_in);
    err_clr = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_pos",       64'(pos),           {28'h0, 18'h20000, 18'h20000});
    chk("rst_pos_valid", 64'(pos_valid),     64'h0);
    chk("rst_mode18",    64'(mode18),        64'h0);
    chk("rst_ch_err",    64'(ch_err_cnt),    64'h0);
    chk("rst_frame_err", 64'(frame_err_cnt), 64'h0);
    chk("rst_link_ok",   64'(link_ok),       64'h0);
    chk("rst_status",    64'(xy_status),     64'h1);
    cnt_rstn = 1'b1;
    repeat (3) @(negedge clk_in);

    // 1: two 16-bit frames
    send_frame({3'b001, 16'h1234, 1'b0}, {3'b001, 16'hFFFF, 1'b1});
    chk("t1_pos_x",   64'(pos[17:0]),  64'h048D0);
    chk("t1_pos_y",   64'(pos[35:18]), 64'h3FFFC);
    chk("t1_pv_x",    64'(pv_x - px0), 64'd1);
    chk("t1_pv_y",    64'(pv_y - py0), 64'd1);
    chk("t1_mode18",  64'(mode18),     64'h0);
    chk("t1_link_ok", 64'(link_ok),    64'h1);
    chk("t1_status",  64'(xy_status),  64'h0);

    // 2: 18-bit frame on X, 16-bit zero on Y
    send_frame({1'b1, 18'h2ABCD, 1'b0}, {3'b001, 16'h0000, 1'b1});
    chk("t2_pos_x",  64'(pos[17:0]),  64'h2ABCD);
    chk("t2_pos_y",  64'(pos[35:18]), 64'h0);
    chk("t2_mode18", 64'(mode18),     64'h1);
    chk("t2_pv_x",   64'(pv_x - px0), 64'd1);

    // 3: parity error on X only, then clear
    send_frame({3'b001, 16'h1234, 1'b1}, {3'b001, 16'h0001, 1'b0});
    chk("t3_pos_x",  64'(pos[17:0]),  64'h2ABCD);
    chk("t3_pos_y",  64'(pos[35:18]), 64'h00004);
    chk("t3_pv_x",   64'(pv_x - px0), 64'd0);
    chk("t3_pv_y",   64'(pv_y - py0), 64'd1);
    chk("t3_mode18", 64'(mode18),     64'h1);
    chk("t3_ch_err", 64'(ch_err_cnt), 64'h0000_0001);
    chk("t3_status", 64'(xy_status),  64'h1);
    pulse_clr();
    chk("t3_clr_ch_err", 64'(ch_err_cnt), 64'h0);
    chk("t3_clr_status", 64'(xy_status),  64'h0);

    // 4: sync drops after 15 bits, then a restart mid-frame followed by a good frame
    px0 = pv_x;
    py0 = pv_y;
    send_bits({3'b001, 16'h1234, 1'b0}, {3'b001, 16'hFFFF, 1'b1}, 15, 16);
    repeat (6) @(negedge clk_in);
    chk("t4_frame_err1", 64'(frame_err_cnt),          64'd1);
    chk("t4_no_pv",      64'(pv_x + pv_y - px0 - py0), 64'd0);
    chk("t4_status",     64'(xy_status),              64'h1);
    send_bits(20'hFFFFF, 20'h55555, 10, 11);
    send_frame({3'b001, 16'hA5A5, 1'b1}, {3'b001, 16'h0F0F, 1'b1});
    chk("t4_frame_err2", 64'(frame_err_cnt), 64'd2);
    chk("t4_pos_x",      64'(pos[17:0]),     64'h29694);
    chk("t4_pos_y",      64'(pos[35:18]),    64'h03C3C);
    chk("t4_pv_x",       64'(pv_x - px0),    64'd1);
    pulse_clr();
    chk("t4_clr_status", 64'(xy_status), 64'h0);

    // 5: link timeout; drop lands after sync pipeline, edge detect and two register stages
    while (cyc - rise_cyc < TMO - 5) @(negedge clk_in);
    chk("t5_link_before", 64'(link_ok), 64'h1);
    while (link_ok !== 1'b0 && cyc - rise_cyc < TMO + 200) @(negedge clk_in);
    chk("t5_drop_cycle", 64'(cyc - rise_cyc), 64'(TMO + 4));
    repeat (2) @(negedge clk_in);
    chk("t5_status", 64'(xy_status), 64'h1);
    chk("t5_pos",    64'(pos),       {28'h0, 18'h03C3C, 18'h29694});
    send_frame({1'b1, 18'h2ABCD, 1'b0}, {3'b001, 16'h0000, 1'b1});
    chk("t5_link_back",   64'(link_ok),   64'h1);
    chk("t5_status_back", 64'(xy_status), 64'h0);

    // 6: reset mid-frame, recovery, then counter saturation
    send_frame({1'b1, 18'h15432, 1'b0}, {3'b001, 16'h0000, 1'b0});
    chk("t6_pre_pos_x",  64'(pos[17:0]),  64'h15432);
    chk("t6_pre_ch_err", 64'(ch_err_cnt), 64'h0001_0000);
    send_bits({3'b001, 16'h1234, 1'b0}, {3'b001, 16'hFFFF, 1'b1}, 19, 10);
    cnt_rstn = 1'b0;
    #1;
    chk("t6_rst_pos",    64'(pos),        {28'h0, 18'h20000, 18'h20000});
    chk("t6_rst_mode18", 64'(mode18),     64'h0);
    chk("t6_rst_ch_err", 64'(ch_err_cnt), 64'h0);
    chk("t6_rst_link",   64'(link_ok),    64'h0);
    chk("t6_rst_status", 64'(xy_status),  64'h1);
    xy_sync = 1'b0;
    xy_data = 2'b00;
    repeat (3) @(negedge clk_in);
    cnt_rstn = 1'b1;
    repeat (3) @(negedge clk_in);
    send_frame({3'b001, 16'h1234, 1'b0}, {3'b001, 16'hFFFF, 1'b1});
    chk("t6_pos",       64'(pos),           {28'h0, 18'h3FFFC, 18'h048D0});
    chk("t6_pv_x",      64'(pv_x - px0),    64'd1);
    chk("t6_link",      64'(link_ok),       64'h1);
    chk("t6_frame_err", 64'(frame_err_cnt), 64'd0);

    force dut.ch_err_cnt_r = 32'h0000_FFFF;
    @(posedge clk_in);
    @(negedge clk_in);
    release dut.ch_err_cnt_r;
    chk("t6_forced", 64'(ch_err_cnt), 64'h0000_FFFF);
    send_frame({3'b001, 16'h1234, 1'b1}, {3'b001, 16'h0001, 1'b0});
    chk("t6_sat",    64'(ch_err_cnt),  64'h0000_FFFF);
    chk("t6_sat_py", 64'(pos[35:18]),  64'h00004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
